sine_code_sequencer: RTL and testbench
======================================

Name: sine_code_sequencer

Overview:
- Upstream feeder and result collector for the sine-angle code decoder (decoder_type_1).
- Buffers incoming angle codes in a small FIFO and issues them one at a time to the decoder as single-cycle decode_start pulses with a stable code.
- Captures each data_ready/out_value result and presents it downstream on a valid/ready interface.
- Guards against a non-responding decoder with a timeout.

Parameters:
- DATA_WIDTH, 32, width of decoded value.
- CODE_WIDTH, 9, width of angle code.
- FIFO_DEPTH, 8, code FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 7, WAIT cycles allowed before abort (≥3).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  code offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_code  in  CODE_WIDTH  code payload.
- dec_start  out  1  decode request pulse to decoder.
- dec_code  out  CODE_WIDTH  code to decoder, held stable ISSUE through WAIT.
- dec_ready  in  1  decoder result strobe (one cycle).
- dec_value  in  DATA_WIDTH  decoder result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_value  out  DATA_WIDTH  captured result.
- out_code  out  CODE_WIDTH  code that produced out_value.
- err_timeout  out  1  one-cycle pulse on aborted decode.
- busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- **Reset values.** All outputs 0, except in_ready=1 once reset is released. FIFO is emptied, FSM goes to IDLE, timeout counter cleared.
- **Decoder contract.**
  - dec_start high in cycle c gives dec_ready high for exactly cycle c+2, with dec_value valid only in that cycle.
  - dec_start must be 1 cycle wide. Holding it retriggers the decoder.
- **FIFO.**
  - Push when in_valid && in_ready.
  - in_ready is derived from registered full only. Push while full is never accepted, even if a pop happens in the same cycle.
  - Pop and push may occur in the same cycle when not full.
  - Pointers wrap modulo FIFO_DEPTH; count has width clog2(FIFO_DEPTH)+1.
- **States:** IDLE, ISSUE, WAIT, HOLD.
  - **IDLE:** if FIFO non-empty, pop the head into dec_code and go to ISSUE.
  - **ISSUE:** dec_start=1 (decoded from state, glitch-free registered state). Clear timeout counter. Go to WAIT.
  - **WAIT:** counter increments each cycle.
    - On dec_ready: register dec_value into out_value, dec_code into out_code, set out_valid=1, go to HOLD.
    - Otherwise, if counter == TIMEOUT_CYCLES-1: pulse err_timeout next cycle, drop the code, go to IDLE.
  - **HOLD:** out_valid=1; out_value and out_code stable.
    - On out_ready: out_valid drops next cycle.
    - If FIFO is non-empty, pop and go directly to ISSUE; else go to IDLE.
- **Latency.**
  - Code pushed at cycle n into an empty FIFO with IDLE FSM: pop at n+1, ISSUE n+2, WAIT n+3..n+4, out_valid from n+5.
  - Steady-state throughput is 1 result per 4 cycles when out_ready=1.
- **Ignored inputs.**
  - dec_ready outside WAIT is ignored, including a late strobe after a timeout or after reset.
- **Reset mid-operation.** The in-flight code and result are discarded; no output or error is generated for them.
- **Ordering.** Results are emitted strictly in push order; timed-out codes are skipped.

Decomposition:
- Package sine_decode_pkg:
  - seq_state_t enum (IDLE, ISSUE, WAIT, HOLD).
  - DEC_LATENCY=2 constant.
  - Default CODE_WIDTH/DATA_WIDTH constants.
- Sub-module code_fifo: parameterised synchronous FIFO with push/pop/full/empty/head.
- Top holds the FSM, timeout counter and output register.

Test Plan:
- **Single code.** Push 9'd3; decoder model returns 32'h0000_1234 at start+2; out_ready=1.
  - dec_start high exactly 1 cycle.
  - out_valid one cycle after dec_ready, with out_value=32'h0000_1234 and out_code=3.
- **Burst.** Push codes 0..7 back-to-back; model returns {23'b0,code}; out_ready=1.
  - All 8 accepted.
  - 8 outputs in order 0..7, spaced 4 cycles apart.
  - busy drops after the last result.
- **Backpressure.** out_ready=0 for 30 cycles while pushing 10 codes.
  - out_valid held and out_value stable.
  - No extra dec_start.
  - in_ready=0 after the FIFO holds 8 codes; the extra push is not accepted.
  - On release, remaining results drain in order.
- **Timeout.** Model ignores code 9'd5; code 9'd6 is queued behind it.
  - err_timeout pulses once, 7 WAIT cycles after ISSUE.
  - No output for 5.
  - 6 is then decoded normally.
  - A late dec_ready injected in IDLE is ignored.
- **Reset during WAIT.** Assert reset_n=0 for 2 cycles.
  - All outputs 0 and FIFO empty.
  - dec_ready pulse right after release produces no out_valid.
  - A new push decodes correctly.
- **Full boundary.** FIFO full, in_valid=1 in the same cycle as the pop.
  - Push not taken (in_ready=0 that cycle).
  - Accepted the next cycle; count never exceeds 8.

Source files
------------

// File: rtl/sine_decode_pkg.sv
// ---------------------------------------------------------------------------
// sine_decode_pkg
//   Shared types and constants for the sine-angle code sequencer and its
//   code FIFO.
//   - seq_state_t            : sequencer FSM states
//   - DEC_LATENCY            : cycles from decode_start to the decoder result
//   - DEFAULT_*              : default widths/sizes used by the sequencer
// ---------------------------------------------------------------------------
package sine_decode_pkg;

    localparam int DEFAULT_CODE_WIDTH     = 9;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 7;

    // The decoder answers a start pulse in cycle c with its result in c+2.
    localparam int DEC_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/code_fifo.sv
// ---------------------------------------------------------------------------
// code_fifo
//   Synchronous FIFO holding angle codes waiting to be decoded.
//   Ports:
//     clock, reset_n : clock, asynchronous active-low reset
//     i_push, i_data : write request and payload (ignored while full)
//     i_pop          : read request (ignored while empty)
//     o_full         : FIFO holds DEPTH entries
//     o_empty        : FIFO holds no entries
//     o_head         : oldest entry, valid while !o_empty
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module code_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read after
    // being written, so resetting it would add logic without changing behaviour.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sine_code_sequencer.sv
// ---------------------------------------------------------------------------
// sine_code_sequencer
//   Feeds buffered angle codes to the sine-angle decoder one at a time and
//   collects each result onto a valid/ready output.
//   Ports:
//     clock, reset_n          : clock, asynchronous active-low reset
//     in_valid/in_ready/in_code : code input (in_ready = FIFO not full)
//     dec_start, dec_code     : one-cycle decode request and its code
//     dec_ready, dec_value    : decoder result strobe and value
//     out_valid/out_ready     : result handshake
//     out_value, out_code     : captured result and the code that made it
//     err_timeout             : one-cycle pulse when a decode is abandoned
//     busy                    : FSM active or codes still queued
// ---------------------------------------------------------------------------
module sine_code_sequencer
    import sine_decode_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int CODE_WIDTH     = DEFAULT_CODE_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    output logic                  dec_start,
    output logic [CODE_WIDTH-1:0] dec_code,
    input  logic                  dec_ready,
    input  logic [DATA_WIDTH-1:0] dec_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic [CODE_WIDTH-1:0] out_code,
    output logic                  err_timeout,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t            r_state;
    logic [CODE_WIDTH-1:0] r_dec_code;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_value;
    logic [CODE_WIDTH-1:0] r_out_code;
    logic                  r_err_timeout;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CODE_WIDTH-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = in_valid && !w_fifo_full;

    // A code leaves the FIFO whenever the FSM is about to enter ISSUE:
    // from IDLE, or from HOLD once the current result is taken.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == HOLD) && out_ready));

    code_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_code_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (in_code),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_dec_code    <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_value   <= '0;
            r_out_code    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_dec_code <= w_fifo_head;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A result arriving on the last allowed cycle still wins.
                    if (dec_ready) begin
                        r_out_value <= dec_value;
                        r_out_code  <= r_dec_code;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_dec_code <= w_fifo_head;
                            r_state    <= ISSUE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // dec_start is a pure decode of the state register, so it is a clean
    // single-cycle pulse with no combinational input path.
    assign dec_start   = (r_state == ISSUE);
    assign dec_code    = r_dec_code;
    assign in_ready    = !w_fifo_full;
    assign out_valid   = r_out_valid;
    assign out_value   = r_out_value;
    assign out_code    = r_out_code;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_sine_code_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sine_code_sequencer
//   Self-checking bench: a behavioural decoder answers each start pulse
//   DEC_LATENCY cycles later (or not at all for codes marked as ignored),
//   and a push-order queue of accepted codes predicts every result and
//   every timeout. Directed scenarios cover latency, burst spacing,
//   backpressure, the full boundary, timeout and reset; a random phase
//   finishes the run.
// ---------------------------------------------------------------------------
module tb_sine_code_sequencer;
    import sine_decode_pkg::*;

    localparam int CW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 7;
    localparam int NCODE = 1 << CW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_code;
    logic          dec_start;
    logic [CW-1:0] dec_code;
    logic          dec_ready;
    logic [DW-1:0] dec_value;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_value;
    logic [CW-1:0] out_code;
    logic          err_timeout;
    logic          busy;

    always #5 clock = ~clock;

    sine_code_sequencer #(
        .DATA_WIDTH     (DW),
        .CODE_WIDTH     (CW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .dec_start   (dec_start),
        .dec_code    (dec_code),
        .dec_ready   (dec_ready),
        .dec_value   (dec_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_code    (out_code),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    // Scoreboard and bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [DW-1:0] dec_tbl [NCODE];
    bit            ign_tbl [NCODE];

    bit            pend_v    [DEC_LATENCY];
    logic [CW-1:0] pend_code [DEC_LATENCY];
    bit            inject = 1'b0;

    logic [CW-1:0] exp_q   [$];   // accepted codes awaiting result or timeout
    logic [CW-1:0] issue_q [$];   // accepted codes awaiting their start pulse
    int            hs_cyc  [$];   // cycles in which a result was taken

    int acc_cnt = 0;
    int hs_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int last_push_cyc = 0;
    int last_start_cyc = 0;
    int last_rdy_cyc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Advance to the next falling edge, observe the DUT, run the decoder model.
    task automatic tick();
        logic [CW-1:0] code;
        @(negedge clock);
        cyc++;
        if (dec_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            check("start_has_code", 64'(issue_q.size() != 0), 64'd1);
            if (issue_q.size() != 0) begin
                code = issue_q.pop_front();
                check("dec_code_order", 64'(dec_code), 64'(code));
            end
        end
        if (err_timeout) begin
            err_cnt++;
            check("timeout_delay", 64'(cyc - last_start_cyc), 64'(TO + 1));
            check("timeout_has_code", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                code = exp_q.pop_front();
                check("timeout_code_ignored", 64'(ign_tbl[code]), 64'd1);
            end
        end
        dec_ready = 1'b0;
        dec_value = $urandom;
        if (inject) begin
            dec_ready = 1'b1;
            inject    = 1'b0;
        end else if (pend_v[DEC_LATENCY-1]) begin
            dec_ready    = 1'b1;
            dec_value    = dec_tbl[pend_code[DEC_LATENCY-1]];
            last_rdy_cyc = cyc;
        end
        for (int i = DEC_LATENCY - 1; i > 0; i--) begin
            pend_v[i]    = pend_v[i-1];
            pend_code[i] = pend_code[i-1];
        end
        pend_v[0]    = dec_start && !ign_tbl[dec_code];
        pend_code[0] = dec_code;
    endtask

    // Drive one cycle of inputs; record accepted pushes and taken results.
    task automatic step(input bit v, input logic [CW-1:0] code, input bit ordy);
        logic [CW-1:0] c;
        in_valid  = v;
        in_code   = code;
        out_ready = ordy;
        if (v && in_ready) begin
            exp_q.push_back(code);
            issue_q.push_back(code);
            acc_cnt++;
            last_push_cyc = cyc;
        end
        if (out_valid && ordy) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            check("result_has_code", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                c = exp_q.pop_front();
                check("out_code", 64'(out_code), 64'(c));
                check("out_value", 64'(out_value), 64'(dec_tbl[c]));
            end
        end
        tick();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check(tag, 64'(exp_q.size() != 0 || busy), 64'd0);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_out_valid"},   64'(out_valid),   64'd0);
        check({tag, "_out_value"},   64'(out_value),   64'd0);
        check({tag, "_out_code"},    64'(out_code),    64'd0);
        check({tag, "_dec_start"},   64'(dec_start),   64'd0);
        check({tag, "_dec_code"},    64'(dec_code),    64'd0);
        check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
    endtask

    initial begin
        int first_ov, s0, a0, h0, e0, n, n_bad, n_ov;
        logic [DW-1:0] held;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        dec_ready = 1'b0;
        dec_value = '0;
        for (int i = 0; i < NCODE; i++) begin
            dec_tbl[i] = DW'(i);
            ign_tbl[i] = 1'b0;
        end
        for (int i = 0; i < DEC_LATENCY; i++) begin
            pend_v[i]    = 1'b0;
            pend_code[i] = '0;
        end

        // Reset state
        tick();
        tick();
        check_quiet_outputs("reset");
        reset_n = 1'b1;
        tick();
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Single code: latency and pulse width
        dec_tbl[3] = 32'h0000_1234;
        s0 = start_cnt;
        h0 = hs_cnt;
        first_ov = -1;
        step(1'b1, 9'd3, 1'b1);
        n = last_push_cyc;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && first_ov < 0) first_ov = cyc;
            step(1'b0, '0, 1'b1);
        end
        check("single_start_cycle", 64'(last_start_cyc - n), 64'd2);
        check("single_start_pulses", 64'(start_cnt - s0), 64'd1);
        check("single_ovalid_cycle", 64'(first_ov - n), 64'd5);
        check("single_ovalid_after_rdy", 64'(first_ov - last_rdy_cyc), 64'd1);
        check("single_results", 64'(hs_cnt - h0), 64'd1);
        dec_tbl[3] = 32'd3;

        // Burst of codes 0..7
        a0 = acc_cnt;
        hs_cyc.delete();
        for (int c = 0; c < 8; c++) step(1'b1, CW'(c), 1'b1);
        drain("burst_drain", 80);
        check("burst_accepted", 64'(acc_cnt - a0), 64'd8);
        check("burst_results", 64'(hs_cyc.size()), 64'd8);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("burst_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd4);
        if (hs_cyc.size() != 0)
            check("burst_busy_drop", 64'(cyc - hs_cyc[hs_cyc.size()-1]), 64'd1);

        // Backpressure: out_ready low for 30 cycles while offering 10 codes
        a0 = acc_cnt;
        s0 = start_cnt;
        h0 = hs_cnt;
        n_bad = 0;
        first_ov = -1;
        held = '0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, CW'(100 + (i < 10 ? i : 9)), 1'b0);
            if (first_ov >= 0 && (!out_valid || out_value != held)) n_bad++;
            if (out_valid && first_ov < 0) begin
                first_ov = cyc;
                held = out_value;
            end
        end
        check("bp_accepted", 64'(acc_cnt - a0), 64'd9);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_hold_stable", 64'(n_bad), 64'd0);
        check("bp_single_start", 64'(start_cnt - s0), 64'd1);
        check("bp_out_valid", 64'(out_valid), 64'd1);

        // Full boundary: pop and offered push in the same cycle
        check("full_pop_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, CW'(109), 1'b1);
        check("full_pop_no_push", 64'(acc_cnt - a0), 64'd9);
        check("full_next_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, CW'(109), 1'b1);
        check("full_next_push", 64'(acc_cnt - a0), 64'd10);
        check("full_again", 64'(in_ready), 64'd0);
        drain("bp_drain", 120);
        check("bp_results", 64'(hs_cnt - h0), 64'd10);

        // Timeout: 5 is never answered, 6 is queued behind it
        ign_tbl[5] = 1'b1;
        e0 = err_cnt;
        h0 = hs_cnt;
        step(1'b1, 9'd5, 1'b1);
        step(1'b1, 9'd6, 1'b1);
        drain("timeout_drain", 60);
        check("timeout_pulses", 64'(err_cnt - e0), 64'd1);
        check("timeout_results", 64'(hs_cnt - h0), 64'd1);
        inject = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            if (out_valid || busy) n_ov++;
        end
        check("late_ready_ignored", 64'(n_ov), 64'd0);
        ign_tbl[5] = 1'b0;

        // Reset while waiting for the decoder
        s0 = start_cnt;
        step(1'b1, 9'd20, 1'b1);
        n = 0;
        while (start_cnt == s0 && n < 10) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("rst_reached_issue", 64'(start_cnt - s0), 64'd1);
        step(1'b0, '0, 1'b1);
        reset_n = 1'b0;
        tick();
        check_quiet_outputs("rst_wait");
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        issue_q.delete();
        inject = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            if (out_valid || busy || !in_ready) n_ov++;
        end
        check("rst_late_ready_ignored", 64'(n_ov), 64'd0);
        h0 = hs_cnt;
        step(1'b1, 9'd21, 1'b1);
        drain("rst_new_drain", 40);
        check("rst_new_result", 64'(hs_cnt - h0), 64'd1);

        // Random traffic against the push-order model
        for (int i = 0; i < NCODE; i++) begin
            dec_tbl[i] = $urandom;
            ign_tbl[i] = ($urandom_range(0, 7) == 0);
        end
        a0 = acc_cnt;
        h0 = hs_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 600; i++)
            step(bit'($urandom_range(0, 1)), CW'($urandom), ($urandom_range(0, 3) != 0));
        drain("rand_drain", 400);
        check("rand_accounting", 64'(acc_cnt - a0), 64'((hs_cnt - h0) + (err_cnt - e0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
